// File: rtl/uart_frame_crc_parser.sv
// Frames the UART byte stream as header, fixed-length payload and CRC-8 (poly 0x07).
// Good frames update rev_data and pulse pack_done; CRC errors and stalled frames are dropped and counted.
module uart_frame_crc_parser #(
  parameter int         PAYLOAD_LEN = 11,
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                     clk_50M,
  input  logic                     rst,
  input  logic [7:0]               uart_data,
  input  logic                     uart_done,
  output logic [PAYLOAD_LEN*8-1:0] rev_data,
  output logic                     pack_done,
  output logic                     crc_err,
  output logic                     timeout_err,
  output logic [7:0]               frame_cnt,
  output logic [7:0]               err_cnt,
  output logic                     busy
);

  localparam int IDX_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam int GAP_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAYLOAD_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CRC} state_e;

  state_e                   state_q;
  logic [IDX_W-1:0]         idx_q;
  logic [7:0]               crc_q, crc_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic [PAYLOAD_LEN*8-1:0] shadow_q, revData_q;
  logic                     packDone_q, crcErr_q, timeoutErr_q;
  logic [7:0]               frameCnt_q, errCnt_q;
  logic                     gapExpired;

  function automatic logic [7:0] crc8Byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // The gap register holds idle cycles minus one, so reaching the limit means this idle cycle completes the timeout.
  always_comb begin
    crc_d      = crc8Byte(crc_q, uart_data);
    gap_d      = gap_q + 1'b1;
    gapExpired = (gap_q == GAP_LIMIT);
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      crc_q        <= '0;
      gap_q        <= '0;
      shadow_q     <= '0;
      revData_q    <= '0;
      packDone_q   <= 1'b0;
      crcErr_q     <= 1'b0;
      timeoutErr_q <= 1'b0;
      frameCnt_q   <= '0;
      errCnt_q     <= '0;
    end else begin
      packDone_q   <= 1'b0;
      crcErr_q     <= 1'b0;
      timeoutErr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (uart_done && (uart_data == HEADER)) begin
            state_q <= S_PAYLOAD;
            idx_q   <= '0;
            crc_q   <= '0;
            gap_q   <= '0;
          end
        end
        S_PAYLOAD: begin
          if (uart_done) begin
            shadow_q[idx_q*8 +: 8] <= uart_data;
            crc_q <= crc_d;
            gap_q <= '0;
            if (idx_q == LAST_IDX) state_q <= S_CRC;
            else idx_q <= idx_q + 1'b1;
          end else if (gapExpired) begin
            timeoutErr_q <= 1'b1;
            errCnt_q     <= errCnt_q + 8'd1;
            state_q      <= S_IDLE;
          end else begin
            gap_q <= gap_d;
          end
        end
        S_CRC: begin
          if (uart_done) begin
            gap_q   <= '0;
            state_q <= S_IDLE;
            if (uart_data == crc_q) begin
              revData_q  <= shadow_q;
              packDone_q <= 1'b1;
              frameCnt_q <= frameCnt_q + 8'd1;
            end else begin
              crcErr_q <= 1'b1;
              errCnt_q <= errCnt_q + 8'd1;
            end
          end else if (gapExpired) begin
            timeoutErr_q <= 1'b1;
            errCnt_q     <= errCnt_q + 8'd1;
            state_q      <= S_IDLE;
          end else begin
            gap_q <= gap_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rev_data    = revData_q;
  assign pack_done   = packDone_q;
  assign crc_err     = crcErr_q;
  assign timeout_err = timeoutErr_q;
  assign frame_cnt   = frameCnt_q;
  assign err_cnt     = errCnt_q;
  assign busy        = (state_q == S_PAYLOAD) || (state_q == S_CRC);

endmodule

// File: tb/tb_uart_frame_crc_parser.sv
// Bench for uart_frame_crc_parser: a frame-level reference model checked every cycle,
// plus hand-computed expectations for the known CRC vectors, timeout latency and counter wrap.
module tb_uart_frame_crc_parser;

  localparam int         LEN  = 11;
  localparam int         LEN9 = 9;
  localparam logic [7:0] HDR  = 8'hA5;
  localparam int         TCYC = 40;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        uart_data;
  logic              uart_done;
  logic [LEN*8-1:0]  rev_data;
  logic              pack_done, crc_err, timeout_err, busy;
  logic [7:0]        frame_cnt, err_cnt;

  logic [7:0]        data9;
  logic              done9;
  logic [LEN9*8-1:0] rev_data9;
  logic              pack_done9, crc_err9, timeout_err9, busy9;
  logic [7:0]        frame_cnt9, err_cnt9;

  always #10 clk = ~clk;

  uart_frame_crc_parser #(.PAYLOAD_LEN(LEN), .HEADER(HDR), .TIMEOUT_CYC(TCYC)) dut (
    .clk_50M(clk), .rst(rst), .uart_data(uart_data), .uart_done(uart_done),
    .rev_data(rev_data), .pack_done(pack_done), .crc_err(crc_err), .timeout_err(timeout_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .busy(busy)
  );

  uart_frame_crc_parser #(.PAYLOAD_LEN(LEN9), .HEADER(HDR), .TIMEOUT_CYC(TCYC)) dut9 (
    .clk_50M(clk), .rst(rst), .uart_data(data9), .uart_done(done9),
    .rev_data(rev_data9), .pack_done(pack_done9), .crc_err(crc_err9), .timeout_err(timeout_err9),
    .frame_cnt(frame_cnt9), .err_cnt(err_cnt9), .busy(busy9)
  );

  int tests = 0;
  int fails = 0;
  bit checkEn = 1'b0;

  bit               inFrame = 1'b0;
  logic [7:0]       got[$];
  int               silence = 0;
  logic [LEN*8-1:0] expRev = '0;
  logic             expPack = 1'b0, expCrcErr = 1'b0, expTimeout = 1'b0;
  logic [7:0]       expFrames = '0, expErrs = '0;

  // Remainder of message*x^8 modulo x^8+x^2+x+1, shifting the augmented message in bit by bit.
  function automatic logic [7:0] crcOf(input logic [7:0] msg[$]);
    logic [7:0] r;
    logic       top, bitIn;
    int         nMsg;
    r = 8'h00;
    nMsg = msg.size() * 8;
    for (int b = 0; b < nMsg + 8; b++) begin
      bitIn = (b < nMsg) ? msg[b / 8][7 - (b % 8)] : 1'b0;
      top   = r[7];
      r     = {r[6:0], bitIn};
      if (top) r = r ^ 8'h07;
    end
    return r;
  endfunction

  function automatic logic [7:0] crcFor(input logic [LEN*8-1:0] pl);
    logic [7:0] q[$];
    for (int k = 0; k < LEN; k++) q.push_back(pl[k*8 +: 8]);
    return crcOf(q);
  endfunction

  always @(posedge clk) begin
    expPack = 1'b0; expCrcErr = 1'b0; expTimeout = 1'b0;
    if (rst) begin
      inFrame = 1'b0; got.delete(); silence = 0;
      expRev = '0; expFrames = '0; expErrs = '0;
    end else if (!inFrame) begin
      if (uart_done && uart_data == HDR) begin
        inFrame = 1'b1; got.delete(); silence = 0;
      end
    end else if (uart_done) begin
      silence = 0;
      if (got.size() < LEN) begin
        got.push_back(uart_data);
      end else begin
        if (uart_data == crcOf(got)) begin
          expRev = '0;
          foreach (got[k]) expRev[k*8 +: 8] = got[k];
          expPack = 1'b1;
          expFrames = expFrames + 8'd1;
        end else begin
          expCrcErr = 1'b1;
          expErrs = expErrs + 8'd1;
        end
        inFrame = 1'b0;
      end
    end else begin
      silence++;
      if (silence == TCYC - 1) begin
        expTimeout = 1'b1;
        expErrs = expErrs + 8'd1;
        inFrame = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("pack_done", 128'(pack_done), 128'(expPack));
      checkOutput("crc_err", 128'(crc_err), 128'(expCrcErr));
      checkOutput("timeout_err", 128'(timeout_err), 128'(expTimeout));
      checkOutput("rev_data", 128'(rev_data), 128'(expRev));
      checkOutput("frame_cnt", 128'(frame_cnt), 128'(expFrames));
      checkOutput("err_cnt", 128'(err_cnt), 128'(expErrs));
      checkOutput("busy", 128'(busy), 128'(inFrame));
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    uart_data = b;
    uart_done = 1'b1;
    @(negedge clk);
    uart_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [LEN*8-1:0] pl, input logic [7:0] crc, input int gap);
    applyStimulus(HDR, gap);
    for (int k = 0; k < LEN; k++) applyStimulus(pl[k*8 +: 8], gap);
    applyStimulus(crc, 0);
  endtask

  task automatic send9(input logic [7:0] b);
    data9 = b;
    done9 = 1'b1;
    @(negedge clk);
    done9 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [LEN*8-1:0]  pl;
    logic [LEN9*8-1:0] vec9;
    int waited;

    rst = 1'b1; uart_data = '0; uart_done = 1'b0; data9 = '0; done9 = 1'b0;
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    rst = 1'b0;
    checkOutput("reset_frame_cnt", 128'(frame_cnt), 128'(0));
    checkOutput("reset_rev_data", 128'(rev_data), 128'(0));

    pl = '0;
    pl[87:80] = 8'h01;
    sendFrame(pl, 8'h07, 0);
    checkOutput("good_pack_done", 128'(pack_done), 128'(1));
    checkOutput("good_rev_data", 128'(rev_data), {40'h0, 8'h01, 80'h0});
    checkOutput("good_frame_cnt", 128'(frame_cnt), 128'(1));

    sendFrame(pl, 8'h08, 0);
    checkOutput("bad_crc_err", 128'(crc_err), 128'(1));
    checkOutput("bad_pack_done", 128'(pack_done), 128'(0));
    checkOutput("bad_err_cnt", 128'(err_cnt), 128'(1));
    checkOutput("bad_rev_kept", 128'(rev_data), {40'h0, 8'h01, 80'h0});

    send9(HDR);
    for (int k = 0; k < LEN9; k++) send9(8'(8'h31 + k));
    send9(8'hF4);
    vec9 = 72'h39_38_37_36_35_34_33_32_31;
    checkOutput("vec9_pack_done", 128'(pack_done9), 128'(1));
    checkOutput("vec9_crc_err", 128'(crc_err9), 128'(0));
    checkOutput("vec9_rev_data", 128'(rev_data9), 128'(vec9));

    applyStimulus(HDR, 0);
    applyStimulus(8'h11, 0); applyStimulus(8'h22, 0);
    applyStimulus(8'h33, 0); applyStimulus(8'h44, 0);
    waited = 0;
    while (!timeout_err && waited < 3 * TCYC) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("timeout_latency", 128'(waited), 128'(TCYC - 1));
    checkOutput("timeout_busy", 128'(busy), 128'(0));
    checkOutput("timeout_err_cnt", 128'(err_cnt), 128'(2));
    for (int k = 0; k < LEN; k++) pl[k*8 +: 8] = 8'(8'h10 * k + 3);
    sendFrame(pl, crcFor(pl), 2);
    checkOutput("after_timeout_frame_cnt", 128'(frame_cnt), 128'(2));

    applyStimulus(8'h00, 1); applyStimulus(8'hFF, 1); applyStimulus(8'h5A, 1);
    checkOutput("garbage_busy", 128'(busy), 128'(0));
    checkOutput("garbage_err_cnt", 128'(err_cnt), 128'(2));
    for (int k = 0; k < LEN; k++) pl[k*8 +: 8] = 8'(8'h21 + k);
    pl[7:0] = HDR;
    pl[31:24] = HDR;
    sendFrame(pl, crcFor(pl), 0);
    checkOutput("hdr_in_payload_byte0", 128'(rev_data[7:0]), 128'(8'hA5));
    checkOutput("hdr_in_payload_byte3", 128'(rev_data[31:24]), 128'(8'hA5));
    checkOutput("hdr_in_payload_cnt", 128'(frame_cnt), 128'(3));

    for (int k = 0; k < LEN; k++) pl[k*8 +: 8] = 8'(8'hC0 ^ k);
    sendFrame(pl, crcFor(pl), TCYC - 2);
    checkOutput("edge_gap_pack_done", 128'(pack_done), 128'(1));
    checkOutput("edge_gap_err_cnt", 128'(err_cnt), 128'(2));

    applyStimulus(HDR, 0);
    applyStimulus(8'h01, 0); applyStimulus(8'h02, 0); applyStimulus(8'h03, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_busy", 128'(busy), 128'(0));
    checkOutput("midreset_frame_cnt", 128'(frame_cnt), 128'(0));
    checkOutput("midreset_err_cnt", 128'(err_cnt), 128'(0));
    checkOutput("midreset_rev_data", 128'(rev_data), 128'(0));

    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < LEN; k++) pl[k*8 +: 8] = 8'(i * 13 + k * 7);
      sendFrame(pl, crcFor(pl), 0);
      if (i == 0) checkOutput("wrap_first_cnt", 128'(frame_cnt), 128'(1));
    end
    checkOutput("wrap_frame_cnt", 128'(frame_cnt), 128'(0));
    checkOutput("wrap_err_cnt", 128'(err_cnt), 128'(0));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
